egg_alarm: RTL and testbench



---
 rtl/egg_timer.sv | 29 ++
 rtl/edge_strobe.sv | 29 ++
 rtl/egg_alarm.sv | 158 +++++++++++++++
 tb/tb_egg_alarm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer.sv
// Shared definitions for the egg timer alarm: state encoding and BCD helpers.
package egg_timer;

   localparam logic [1:0] ENC_IDLE    = 2'd0;
   localparam logic [1:0] ENC_ARMED   = 2'd1;
   localparam logic [1:0] ENC_RINGING = 2'd2;
   localparam logic [1:0] ENC_HOLD    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = ENC_IDLE,
      ST_ARMED   = ENC_ARMED,
      ST_RINGING = ENC_RINGING,
      ST_HOLD    = ENC_HOLD
   } state_t;

   localparam int RING_CNT_W = 8;

   // Digits above 9 are not BCD zero, so a corrupt display never counts as expired.
   function automatic logic bcd_is_zero(
      input logic [3:0] sec_ones,
      input logic [3:0] sec_tens,
      input logic [3:0] min_ones,
      input logic [3:0] min_tens
   );
      return (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
             (min_ones == 4'd0) && (min_tens == 4'd0);
   endfunction

endpackage

// File: rtl/edge_strobe.sv
// Synchronizer chain followed by a rising-edge detector; one-cycle strobe per edge.
module edge_strobe #(
   parameter int STAGES = 2
) (
   input  logic i_clk_sys,
   input  logic i_rst_b,
   input  logic i_d,
   output logic o_strobe
);

   logic [STAGES-1:0] r_sync;
   logic              r_dly;

   always_ff @(posedge i_clk_sys) begin
      if (!i_rst_b) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_dly <= r_sync[STAGES-1];
      end
   end

   assign o_strobe = r_sync[STAGES-1] & ~r_dly;

endmodule

// File: rtl/egg_alarm.sv
// Alarm sequencer for the egg timer: rings at 00:00, silences on ack or after
// ALARM_SECONDS of ringing, and holds until a new time is loaded.
//
//   state   | meaning
//   IDLE    | no countdown armed
//   ARMED   | countdown running with a nonzero time
//   RINGING | time expired, buzzer and LED active
//   HOLD    | silenced, waiting for a new nonzero time
module egg_alarm
   import egg_timer::*;
#(
   parameter int ALARM_SECONDS = 30,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       CLK100MHZ,
   input  logic       reset,
   input  logic       pulse_1Hz,
   input  logic       pulse_500Hz,
   input  logic       enable_countdown,
   input  logic [3:0] second_ones,
   input  logic [3:0] second_tens,
   input  logic [3:0] minute_ones,
   input  logic [3:0] minute_tens,
   input  logic       ack,
   output logic       alarm_active,
   output logic       buzzer,
   output logic       led_flash,
   output logic       alarm_done,
   output logic       timed_out
);

   localparam logic [RING_CNT_W:0] RING_LIMIT = (RING_CNT_W+1)'(ALARM_SECONDS);

   logic                  w_tick_1hz;
   logic                  w_tick_500hz;
   logic                  w_ack;
   logic                  w_zero;
   logic [RING_CNT_W:0]   w_cnt_inc;
   logic                  w_ring_done;
   logic                  w_exit_timeout;
   logic                  w_ring_enter;
   logic                  w_ring_exit;
   logic                  w_arm_enter;
   state_t                w_state_nxt;

   state_t                r_state;
   logic [RING_CNT_W-1:0] r_ring_cnt;
   logic                  r_led;
   logic                  r_tone;
   logic                  r_alarm_active;
   logic                  r_buzzer;
   logic                  r_alarm_done;
   logic                  r_timed_out;

   edge_strobe #(.STAGES(SYNC_STAGES)) u_edge_1hz (
      .i_clk_sys (CLK100MHZ),
      .i_rst_b   (reset),
      .i_d       (pulse_1Hz),
      .o_strobe  (w_tick_1hz)
   );

   edge_strobe #(.STAGES(SYNC_STAGES)) u_edge_500hz (
      .i_clk_sys (CLK100MHZ),
      .i_rst_b   (reset),
      .i_d       (pulse_500Hz),
      .o_strobe  (w_tick_500hz)
   );

   edge_strobe #(.STAGES(SYNC_STAGES)) u_edge_ack (
      .i_clk_sys (CLK100MHZ),
      .i_rst_b   (reset),
      .i_d       (ack),
      .o_strobe  (w_ack)
   );

   assign w_zero      = bcd_is_zero(second_ones, second_tens, minute_ones, minute_tens);
   assign w_cnt_inc   = {1'b0, r_ring_cnt} + 1'b1;
   // Timeout fires on the strobe that brings the count up to the limit, so a
   // simultaneous ack strobe can win the tie.
   assign w_ring_done = w_tick_1hz && (w_cnt_inc >= RING_LIMIT);

   always_comb begin
      w_state_nxt    = r_state;
      w_exit_timeout = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable_countdown && !w_zero) w_state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (w_zero)                  w_state_nxt = ST_RINGING;
            else if (!enable_countdown)  w_state_nxt = ST_IDLE;
         end
         ST_RINGING: begin
            if (w_ack) begin
               w_state_nxt = ST_HOLD;
            end else if (w_ring_done) begin
               w_state_nxt    = ST_HOLD;
               w_exit_timeout = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!w_zero) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_ring_enter = (w_state_nxt == ST_RINGING) && (r_state != ST_RINGING);
   assign w_ring_exit  = (r_state == ST_RINGING) && (w_state_nxt != ST_RINGING);
   assign w_arm_enter  = (w_state_nxt == ST_ARMED) && (r_state != ST_ARMED);

   always_ff @(posedge CLK100MHZ) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_ring_cnt     <= '0;
         r_led          <= 1'b0;
         r_tone         <= 1'b0;
         r_alarm_active <= 1'b0;
         r_buzzer       <= 1'b0;
         r_alarm_done   <= 1'b0;
         r_timed_out    <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_alarm_active <= (r_state == ST_RINGING);
         r_alarm_done   <= w_ring_exit;
         r_buzzer       <= r_tone & r_led & r_alarm_active;

         if (w_ring_enter) begin
            r_ring_cnt <= '0;
         end else if ((r_state == ST_RINGING) && w_tick_1hz && (r_ring_cnt != '1)) begin
            r_ring_cnt <= r_ring_cnt + 1'b1;
         end

         if (w_state_nxt != ST_RINGING) begin
            r_led <= 1'b0;
         end else if (w_ring_enter) begin
            r_led <= 1'b1;
         end else if (w_tick_1hz) begin
            r_led <= ~r_led;
         end

         if (w_tick_500hz) r_tone <= ~r_tone;

         if (w_arm_enter) begin
            r_timed_out <= 1'b0;
         end else if (w_exit_timeout) begin
            r_timed_out <= 1'b1;
         end
      end
   end

   assign alarm_active = r_alarm_active;
   assign buzzer       = r_buzzer;
   assign led_flash    = r_led;
   assign alarm_done   = r_alarm_done;
   assign timed_out    = r_timed_out;

endmodule

// File: tb/tb_egg_alarm.sv
// Self-checking bench for egg_alarm: randomized timing, expectations derived
// from the alarm rules (ring on 00:00, silence on ack or after N seconds).
module tb_egg_alarm;

   localparam int AS = 3;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       p1, p500, en, ack;
   logic [3:0] s1, s10, m1, m10;
   logic       o_act, o_buz, o_led, o_done, o_to;

   int n_checks = 0;
   int n_fail   = 0;
   int buz_bad  = 0;
   int buz_seen = 0;

   always #5 clk = ~clk;

   egg_alarm #(.ALARM_SECONDS(AS), .SYNC_STAGES(SS)) dut (
      .CLK100MHZ        (clk),
      .reset            (rst_n),
      .pulse_1Hz        (p1),
      .pulse_500Hz      (p500),
      .enable_countdown (en),
      .second_ones      (s1),
      .second_tens      (s10),
      .minute_ones      (m1),
      .minute_tens      (m10),
      .ack              (ack),
      .alarm_active     (o_act),
      .buzzer           (o_buz),
      .led_flash        (o_led),
      .alarm_done       (o_done),
      .timed_out        (o_to)
   );

   // Free-running 500 Hz stand-in: rising edge every 6 clocks.
   initial begin
      p500 = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 p500 = ~p500;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (o_buz && !o_act) buz_bad++;
         if (o_buz) buz_seen++;
      end
   endtask

   task automatic set_time(input logic [3:0] mt, input logic [3:0] mo,
                           input logic [3:0] st, input logic [3:0] so);
      m10 = mt; m1 = mo; s10 = st; s1 = so;
   endtask

   task automatic load_nonzero();
      do begin
         m10 = 4'($urandom_range(0, 9));
         m1  = 4'($urandom_range(0, 9));
         s10 = 4'($urandom_range(0, 5));
         s1  = 4'($urandom_range(0, 9));
      end while (m10 == 4'd0 && m1 == 4'd0 && s10 == 4'd0 && s1 == 4'd0);
   endtask

   // Start from IDLE or HOLD, arm with a nonzero time, then expire it.
   task automatic arm_and_ring();
      load_nonzero();
      en = 1'b1;
      cyc(2 + int'($urandom_range(0, 4)));
      n_checks++; if (o_act !== 1'b0) begin n_fail++; $display("FAIL armed_idle_act: got %b want 0", o_act); end
      n_checks++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL armed_timed_out_clear: got %b want 0", o_to); end
      if ($urandom_range(0, 1) == 1) en = 1'b0;
      set_time(4'd0, 4'd0, 4'd0, 4'd0);
      cyc(1);
      n_checks++; if (o_led !== 1'b1) begin n_fail++; $display("FAIL ring_entry_led: got %b want 1", o_led); end
      cyc(1);
      n_checks++; if (o_act !== 1'b1) begin n_fail++; $display("FAIL ring_entry_act: got %b want 1", o_act); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; p1 = 1'b0; en = 1'b0; ack = 1'b0;
      set_time(4'd0, 4'd0, 4'd0, 4'd0);
      cyc(3);
      n_checks++; if (o_act  !== 1'b0) begin n_fail++; $display("FAIL reset_act: got %b want 0", o_act); end
      n_checks++; if (o_buz  !== 1'b0) begin n_fail++; $display("FAIL reset_buz: got %b want 0", o_buz); end
      n_checks++; if (o_led  !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b want 0", o_led); end
      n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
      n_checks++; if (o_to   !== 1'b0) begin n_fail++; $display("FAIL reset_to: got %b want 0", o_to); end
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_timeout();
      logic exp_led;
      arm_and_ring();
      buz_seen = 0;
      cyc(16);
      n_checks++; if (buz_seen == 0) begin n_fail++; $display("FAIL buzzer_tone: high cycles %0d want >0", buz_seen); end
      exp_led = 1'b1;
      for (int r = 1; r < AS; r++) begin
         p1 = 1'b1;
         cyc(SS + 1);
         exp_led = ~exp_led;
         n_checks++; if (o_led !== exp_led) begin n_fail++; $display("FAIL led_toggle_%0d: got %b want %b", r, o_led, exp_led); end
         n_checks++; if (o_act !== 1'b1) begin n_fail++; $display("FAIL still_ringing_%0d: got %b want 1", r, o_act); end
         p1 = 1'b0;
         cyc(2 + int'($urandom_range(0, 4)));
      end
      p1 = 1'b1;
      for (int k = 1; k <= SS + 3; k++) begin
         cyc(1);
         n_checks++; if (o_act !== logic'(k < SS + 2)) begin n_fail++; $display("FAIL timeout_act_k%0d: got %b want %b", k, o_act, logic'(k < SS + 2)); end
         n_checks++; if (o_done !== logic'(k == SS + 1)) begin n_fail++; $display("FAIL timeout_done_k%0d: got %b want %b", k, o_done, logic'(k == SS + 1)); end
         n_checks++; if (o_to !== logic'(k >= SS + 1)) begin n_fail++; $display("FAIL timeout_to_k%0d: got %b want %b", k, o_to, logic'(k >= SS + 1)); end
      end
      p1 = 1'b0;
      cyc(4);
      n_checks++; if (o_buz !== 1'b0) begin n_fail++; $display("FAIL timeout_buz_after: got %b want 0", o_buz); end
      n_checks++; if (o_led !== 1'b0) begin n_fail++; $display("FAIL timeout_led_after: got %b want 0", o_led); end
   endtask

   task automatic test_ack();
      int w;
      arm_and_ring();
      p1 = 1'b1; cyc(SS + 1); p1 = 1'b0; cyc(2 + int'($urandom_range(0, 3)));
      w = int'($urandom_range(1, 3));
      ack = 1'b1;
      for (int k = 1; k <= SS + 3; k++) begin
         cyc(1);
         if (k == w) ack = 1'b0;
         n_checks++; if (o_act !== logic'(k < SS + 2)) begin n_fail++; $display("FAIL ack_act_k%0d: got %b want %b", k, o_act, logic'(k < SS + 2)); end
         n_checks++; if (o_done !== logic'(k == SS + 1)) begin n_fail++; $display("FAIL ack_done_k%0d: got %b want %b", k, o_done, logic'(k == SS + 1)); end
      end
      ack = 1'b0;
      n_checks++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL ack_timed_out: got %b want 0", o_to); end
   endtask

   task automatic test_tie();
      int pulses;
      arm_and_ring();
      for (int r = 1; r < AS; r++) begin
         p1 = 1'b1; cyc(SS + 1); p1 = 1'b0; cyc(2 + int'($urandom_range(0, 3)));
      end
      pulses = 0;
      ack = 1'b1; p1 = 1'b1;
      for (int k = 1; k <= SS + 5; k++) begin
         cyc(1);
         if (k == 1) ack = 1'b0;
         if (o_done === 1'b1) pulses++;
         n_checks++; if (o_act !== logic'(k < SS + 2)) begin n_fail++; $display("FAIL tie_act_k%0d: got %b want %b", k, o_act, logic'(k < SS + 2)); end
      end
      p1 = 1'b0;
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL tie_done_pulses: got %0d want 1", pulses); end
      n_checks++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL tie_timed_out: got %b want 0", o_to); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 6; i++) begin
         en = ~en;
         if (i == 2) begin p1 = 1'b1; cyc(SS + 1); p1 = 1'b0; end
         cyc(1 + int'($urandom_range(0, 3)));
         n_checks++; if (o_act !== 1'b0 || o_led !== 1'b0) begin n_fail++; $display("FAIL hold_no_ring_%0d: act=%b led=%b want 0 0", i, o_act, o_led); end
      end
      en = 1'b0;
      set_time(4'd0, 4'd1, 4'd0, 4'd0);
      cyc(2);
      en = 1'b1;
      cyc(2);
      set_time(4'd0, 4'd0, 4'd0, 4'd0);
      cyc(2);
      n_checks++; if (o_act !== 1'b1) begin n_fail++; $display("FAIL rearm_ring: got %b want 1", o_act); end
      ack = 1'b1; cyc(1); ack = 1'b0; cyc(SS + 3);
      n_checks++; if (o_act !== 1'b0) begin n_fail++; $display("FAIL rearm_ack_exit: got %b want 0", o_act); end
      load_nonzero();
      en = 1'b1;
      cyc(3);
      en = 1'b0;
      cyc(2);
      set_time(4'd0, 4'd0, 4'd0, 4'd0);
      cyc(4);
      n_checks++; if (o_act !== 1'b0) begin n_fail++; $display("FAIL disarm_no_ring: got %b want 0", o_act); end
      en = 1'b1;
      cyc(4);
      n_checks++; if (o_act !== 1'b0) begin n_fail++; $display("FAIL idle_zero_no_arm: got %b want 0", o_act); end
      en = 1'b0;
   endtask

   task automatic test_reset_mid();
      arm_and_ring();
      cyc(1 + int'($urandom_range(0, 4)));
      rst_n = 1'b0;
      cyc(1);
      n_checks++; if (o_act  !== 1'b0) begin n_fail++; $display("FAIL midrst_act: got %b want 0", o_act); end
      n_checks++; if (o_buz  !== 1'b0) begin n_fail++; $display("FAIL midrst_buz: got %b want 0", o_buz); end
      n_checks++; if (o_led  !== 1'b0) begin n_fail++; $display("FAIL midrst_led: got %b want 0", o_led); end
      n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", o_done); end
      n_checks++; if (o_to   !== 1'b0) begin n_fail++; $display("FAIL midrst_to: got %b want 0", o_to); end
      cyc(int'($urandom_range(0, 2)));
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cyc(1);
         n_checks++; if (o_done !== 1'b0 || o_act !== 1'b0) begin n_fail++; $display("FAIL postrst_quiet_k%0d: done=%b act=%b want 0 0", k, o_done, o_act); end
      end
   endtask

   task automatic test_digit_a();
      int hits;
      for (int pos = 0; pos < 4; pos++) begin
         set_time(4'd0, 4'd0, 4'd0, 4'd0);
         case (pos)
            0: s1  = 4'hA;
            1: s10 = 4'hA;
            2: m1  = 4'hA;
            default: m10 = 4'hA;
         endcase
         hits = 0;
         en = 1'b1;
         for (int k = 0; k < 12; k++) begin
            if (k == 8) en = 1'b0;
            cyc(1);
            if (o_act !== 1'b0 || o_led !== 1'b0) hits++;
         end
         n_checks++; if (hits != 0) begin n_fail++; $display("FAIL digit_a_pos%0d: ringing cycles %0d want 0", pos, hits); end
      end
      set_time(4'd0, 4'd0, 4'd0, 4'd0);
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_ack();
      test_tie();
      test_hold();
      test_reset_mid();
      test_digit_a();
      n_checks++; if (buz_bad != 0) begin n_fail++; $display("FAIL buzzer_gating: cycles with buzzer and no alarm %0d want 0", buz_bad); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
